// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the 8N1 UART receiver that packs 16-byte frames.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } bit_state_t;

  localparam int FRAME_BYTES      = 16;
  localparam int FRAME_W          = 128;
  localparam int FRAME_CNT_W      = $clog2(FRAME_BYTES);
  localparam int DEF_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Frame output bundle: the receiver drives it (master), the computation master consumes it (slave).
interface uart_frame_rx_if;
  import uart_frame_pkg::*;

  logic [FRAME_W-1:0] rx_data;
  logic               rx_irq;
  logic               frame_err;
  logic               rx_busy;

  modport master (
    output rx_data,
    output rx_irq,
    output frame_err,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input rx_irq,
    input frame_err,
    input rx_busy
  );

endinterface

// File: rtl/uart_rx_byte.sv
// Two-flop synchroniser plus 8N1 bit FSM; byte_vld/byte_err are single-cycle
// strobes asserted in the cycle whose rising edge takes the stop-bit sample.
module uart_rx_byte
  import uart_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] byte_data,
  output logic       byte_vld,
  output logic       byte_err,
  output logic       bit_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_reg;
  logic             rx_s;
  bit_state_t       state_reg, state_next;
  logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;

  assign rx_s = sync_reg[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx_in};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = clk_cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    byte_vld     = 1'b0;
    byte_err     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!rx_s) begin
          state_next   = ST_START;
          clk_cnt_next = '0;
        end
      end

      // Mid-bit check of the start bit rejects glitches shorter than half a bit.
      ST_START: begin
        if (clk_cnt_reg == HALF_CNT) begin
          clk_cnt_next = '0;
          if (!rx_s) begin
            state_next   = ST_DATA;
            bit_idx_next = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (clk_cnt_reg == LAST_CNT) begin
          clk_cnt_next = '0;
          shift_next   = {rx_s, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end

      // Returning to IDLE on the sample edge lets a start bit that follows
      // immediately be caught without losing any clocks.
      ST_STOP: begin
        if (clk_cnt_reg == LAST_CNT) begin
          clk_cnt_next = '0;
          state_next   = ST_IDLE;
          if (rx_s) begin
            byte_vld = 1'b1;
          end else begin
            byte_err = 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next   = ST_IDLE;
        clk_cnt_next = '0;
      end
    endcase
  end

  assign byte_data = shift_reg;
  assign bit_busy  = (state_reg != ST_IDLE);

endmodule

// File: rtl/uart_frame_rx.sv
// Packs 16 UART bytes into a 128-bit word (first byte in the MSBs) and pulses rx_irq.
// Optional inter-byte idle timeout is enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            UART_RX,
  uart_frame_rx_if.master frame
);

  localparam logic [FRAME_CNT_W-1:0] LAST_SLOT = FRAME_CNT_W'(FRAME_BYTES - 1);

  logic [7:0]             byte_data;
  logic                   byte_vld;
  logic                   byte_err;
  logic                   bit_busy;
  logic                   timeout_fire;

  logic [FRAME_W-9:0]     shreg_reg;
  logic [FRAME_CNT_W-1:0] cnt_reg;
  logic [FRAME_W-1:0]     rx_data_reg;
  logic                   rx_irq_reg;
  logic                   frame_err_reg;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clock    (clock),
    .reset    (reset),
    .rx_in    (UART_RX),
    .byte_data(byte_data),
    .byte_vld (byte_vld),
    .byte_err (byte_err),
    .bit_busy (bit_busy)
  );

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

  logic [TO_W-1:0] idle_cnt_reg;
  logic            idle_run;

  // Any activity on the bit FSM, including a rejected start, restarts the idle count.
  assign idle_run     = !bit_busy && (cnt_reg != '0);
  assign timeout_fire = idle_run && (idle_cnt_reg == TO_LAST);

  always_ff @(posedge clock) begin
    if (reset || !idle_run || timeout_fire) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
    end
  end
`else
  // No idle timer: a partial frame waits indefinitely for its remaining bytes.
  assign timeout_fire = (TIMEOUT_BITS < 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_reg     <= '0;
      cnt_reg       <= '0;
      rx_data_reg   <= '0;
      rx_irq_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_irq_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
      if (byte_vld) begin
        shreg_reg <= {shreg_reg[FRAME_W-17:0], byte_data};
        cnt_reg   <= cnt_reg + FRAME_CNT_W'(1);
        if (cnt_reg == LAST_SLOT) begin
          rx_data_reg <= {shreg_reg, byte_data};
          rx_irq_reg  <= 1'b1;
        end
      end else if (byte_err || timeout_fire) begin
        // Stale shreg bytes are simply overwritten by the next frame.
        cnt_reg       <= '0;
        frame_err_reg <= 1'b1;
      end
    end
  end

  assign frame.rx_data   = rx_data_reg;
  assign frame.rx_irq    = rx_irq_reg;
  assign frame.frame_err = frame_err_reg;
  assign frame.rx_busy   = bit_busy | (cnt_reg != '0);

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Serial front end that feeds the computation master. It receives 8N1 UART bytes on `UART_RX` and packs 16 consecutive bytes into one 128-bit word, first byte in the MSBs. For each completed word it presents `rx_data` and pulses `rx_irq` for exactly one clock. Its output ports connect one-to-one to the computation master's `rx_data`/`rx_irq` inputs.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clocks per UART bit (100 MHz / 115200). Legal values are ≥ 4.
- `TIMEOUT_BITS`, default 32: inter-byte idle limit in bit-times. Used only when `FRAME_TIMEOUT_EN` is defined.

Ports:
- `clock`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `UART_RX`  in  1: asynchronous serial input; idle high.
- `rx_data`  out  128: last completed frame; byte 0 at [127:120], byte 15 at [7:0].
- `rx_irq`  out  1: one-cycle pulse when `rx_data` has just been updated.
- `frame_err`  out  1: one-cycle pulse when a partial frame is discarded.
- `rx_busy`  out  1: high while a byte is being received or the partial frame is non-empty.

## Operation
- Input synchroniser:
  - Two flops on `UART_RX`, both reset to 1.
  - All decisions use the second flop (`rx_s`).
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: when `rx_s` == 0, go to START and clear the clock counter.
  - START: at count `CLKS_PER_BIT/2` (integer divide), sample `rx_s`.
    - 0 → go to DATA.
    - 1 → false start; return to IDLE with no other effect.
  - DATA: sample every `CLKS_PER_BIT` clocks, 8 samples, LSB first into the byte register; then go to STOP.
  - STOP: sample after `CLKS_PER_BIT` clocks.
    - 1 → byte valid (internal one-cycle `byte_vld`).
    - 0 → framing error.
    - Either way, return to IDLE in the same cycle.
- Frame assembly:
  - On `byte_vld`: `shreg <= {shreg[119:0], byte}` and `cnt <= cnt + 1`. `cnt` is 4 bits.
  - When `byte_vld` arrives with `cnt` == 15: on the next edge, `rx_data <= {shreg[119:0], byte}`, `rx_irq` = 1, and `cnt` wraps to 0.
- Framing error:
  - The byte is dropped.
  - `cnt` clears to 0 and `shreg` contents are ignored.
  - `frame_err` pulses for one cycle.
  - `rx_data` is unchanged.
- `rx_data` holds its value until the next completed frame; it is never partially updated.
- `rx_busy` = (FSM != IDLE) | (`cnt` != 0).

## Timing
- Reset values:
  - `rx_data` = 0, `rx_irq` = 0, `frame_err` = 0, `rx_busy` = 0.
  - FSM = IDLE, `cnt` = 0, synchroniser = 1.
- Reset has priority over every other event.
  - Reset mid-byte or mid-frame discards all partial state.
  - No pulse is emitted on reset.
- Latency: `rx_irq` rises 1 clock after the STOP sample of byte 15. The stop-bit sample point is 2 clocks (synchroniser) plus about 9.5 bit-times after the start-bit falling edge.
- Any start bit that begins right after the STOP sample is accepted, so back-to-back frames with no idle gap are received without loss.
- `rx_irq` and `frame_err` are never high in the same cycle.

## Configuration
- `FRAME_TIMEOUT_EN` defined:
  - An idle counter runs while FSM is IDLE and `cnt` != 0.
  - When it reaches `TIMEOUT_BITS*CLKS_PER_BIT`, the partial frame is discarded: `cnt` = 0 and `frame_err` pulses for one cycle.
  - The counter clears on any start detect.
- `FRAME_TIMEOUT_EN` undefined:
  - No idle counter.
  - A partial frame waits indefinitely.
  - `frame_err` pulses only on framing errors.

## Structure
- Shared package `uart_frame_pkg`:
  - Bit-FSM state enum.
  - `FRAME_BYTES` = 16, `FRAME_W` = 128.
  - Default `CLKS_PER_BIT`.
- One sub-module, `uart_rx_byte`:
  - Contains the synchroniser and the bit FSM.
  - Outputs `byte`[7:0], `byte_vld`, `byte_err`.
- The top level holds `shreg`, `cnt`, the timeout logic and the output registers.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16.
- Frame: send bytes BE 9B 6F 8B BE 9B 6F 8B 3F BD 7B 2D 3F BD 7B 2D → `rx_data` = 128'hBE9B6F8BBE9B6F8B3FBD7B2D3FBD7B2D and exactly one `rx_irq` pulse, 1 clock after the last STOP sample.
- Glitch: drive `UART_RX` low for 6 clocks → no byte, `rx_busy` returns to 0, no pulses.
- Framing error: 4 good bytes, then byte 0x55 with stop bit = 0 → one `frame_err` pulse and `cnt` = 0. Then 16 bytes 00..0F → `rx_data` = 128'h000102030405060708090A0B0C0D0E0F.
- Back-to-back: two frames with zero idle bits → two `rx_irq` pulses. `rx_data` equals frame 2 after the second pulse.
- Reset: assert reset for 1 clock during bit 3 of byte 7, then send 16 bytes AA → `rx_data` = {16{8'hAA}}. No `frame_err` pulse.
- Timeout (`FRAME_TIMEOUT_EN`): send 10 bytes, idle 33 bit-times → one `frame_err` pulse, `rx_busy` = 0. A following 16-byte frame is received intact.
